// File: rtl/cnt_sequencer_pkg.sv
// Shared definitions for the counter run controller: FSM encoding and
// default datapath widths.
package cnt_sequencer_pkg;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_PRESCALE_W = 8;
    localparam int WRAPS_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Saturating increment for the completed-period counter.
    function automatic logic [WRAPS_W-1:0] sat_inc(input logic [WRAPS_W-1:0] v);
        return (v == {WRAPS_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cnt_sequencer_prescaler.sv
// Rate divider: while enabled, emits a one-cycle tick every div_i+1 cycles.
// The tick is decoded from the current count so the caller sees it in the
// same cycle it is consumed; the count clears on the tick or on clr_i.
module cnt_prescaler
    import cnt_sequencer_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [PRESCALE_W-1:0] div_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] presc_q;
    logic [PRESCALE_W-1:0] presc_d;

    assign tick_o = en_i && (presc_q == div_i);

    // Next count: clear has priority, hold when disabled.
    always_comb begin
        presc_d = presc_q;
        if (clr_i) begin
            presc_d = '0;
        end else if (en_i) begin
            presc_d = tick_o ? '0 : presc_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/cnt_sequencer.sv
// Run controller for the up-counter datapath. Owns the count register, the
// captured run configuration and the run FSM; the prescaler supplies ticks.
//
//   state | meaning
//   IDLE  | waiting for start, cnt holds last value
//   RUN   | prescaler running, cnt advances on each tick
//   HOLD  | paused, cnt and prescaler frozen
module cnt_sequencer
    import cnt_sequencer_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  pause_i,
    input  logic                  auto_reload_i,
    input  logic [WIDTH-1:0]      term_i,
    input  logic [PRESCALE_W-1:0] div_i,
    output logic [WIDTH-1:0]      cnt_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [WRAPS_W-1:0]    wraps_o
);

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]      term_q, term_d;
    logic [PRESCALE_W-1:0] div_q, div_d;
    logic                  auto_q, auto_d;
    logic                  done_q, done_d;
    logic                  busy_q;
    logic [WRAPS_W-1:0]    wraps_q, wraps_d;
    logic                  presc_clr;
    logic                  presc_en;
    logic                  tick;
    logic [WIDTH-1:0]      cnt_inc;

    assign cnt_inc = cnt_q + 1'b1;

    cnt_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_presc (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (presc_clr),
        .en_i    (presc_en),
        .div_i   (div_q),
        .tick_o  (tick)
    );

    // Next-state and datapath decisions; stop outranks start, pause and tick.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        term_d    = term_q;
        div_d     = div_q;
        auto_d    = auto_q;
        wraps_d   = wraps_q;
        done_d    = 1'b0;
        presc_clr = 1'b0;
        presc_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    cnt_d = '0;
                    if (term_i != '0) begin
                        term_d    = term_i;
                        div_d     = div_i;
                        auto_d    = auto_reload_i;
                        wraps_d   = '0;
                        presc_clr = 1'b1;
                        state_d   = ST_RUN;
                    end else begin
                        // Zero-length run completes immediately.
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (pause_i) begin
                    state_d = ST_HOLD;
                end else begin
                    presc_en = 1'b1;
                    if (tick) begin
                        if (cnt_inc == term_q) begin
                            done_d = 1'b1;
                            if (auto_q) begin
                                cnt_d   = '0;
                                wraps_d = sat_inc(wraps_q);
                            end else begin
                                cnt_d   = cnt_inc;
                                state_d = ST_IDLE;
                            end
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (!pause_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and registered outputs; busy is decoded from the next state.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            term_q  <= '0;
            div_q   <= '0;
            auto_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            wraps_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            term_q  <= term_d;
            div_q   <= div_d;
            auto_q  <= auto_d;
            done_q  <= done_d;
            busy_q  <= (state_d == ST_RUN) || (state_d == ST_HOLD);
            wraps_q <= wraps_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign wraps_o = wraps_q;

endmodule

// File: tb/tb_cnt_sequencer.sv
// Directed bench for cnt_sequencer. The stimulus process drives inputs on
// the falling edge and queues the outputs expected after the next rising
// edge; a monitor pops one entry per cycle and compares.
module tb_cnt_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic       auto_reload;
    logic [3:0] term;
    logic [7:0] div;
    logic [3:0] cnt;
    logic       busy;
    logic       done;
    logic [3:0] wraps;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] cnt;
        logic       busy;
        logic       done;
        logic [3:0] wraps;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    bit    stim_done = 1'b0;

    cnt_sequencer dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start),
        .stop_i        (stop),
        .pause_i       (pause),
        .auto_reload_i (auto_reload),
        .term_i        (term),
        .div_i         (div),
        .cnt_o         (cnt),
        .busy_o        (busy),
        .done_o        (done),
        .wraps_o       (wraps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Staged inputs for the next cycle; set by the sequence, applied by cyc.
    logic       s_reset = 1'b0;
    logic       s_start = 1'b0;
    logic       s_stop  = 1'b0;
    logic       s_pause = 1'b0;
    logic       s_auto  = 1'b0;
    logic [3:0] s_term  = 4'd0;
    logic [7:0] s_div   = 8'd0;

    task automatic cyc(input logic [3:0] ec, input logic eb, input logic ed,
                       input logic [3:0] ew, input string nm);
        exp_t e;
        @(negedge clk);
        reset       = s_reset;
        start       = s_start;
        stop        = s_stop;
        pause       = s_pause;
        auto_reload = s_auto;
        term        = s_term;
        div         = s_div;
        e.cnt   = ec;
        e.busy  = eb;
        e.done  = ed;
        e.wraps = ew;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: one expected entry per rising edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if ({cnt, busy, done, wraps} !== e) begin
                    errors++;
                    $display("FAIL %s: got cnt=%0d busy=%0b done=%0b wraps=%0d, want cnt=%0d busy=%0b done=%0b wraps=%0d",
                             nm, cnt, busy, done, wraps, e.cnt, e.busy, e.done, e.wraps);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        auto_reload = 1'b0; term = 4'd0; div = 8'd0;

        // Reset for two cycles.
        s_reset = 1'b0;
        cyc(0, 0, 0, 0, "reset0");
        cyc(0, 0, 0, 0, "reset1");
        s_reset = 1'b1;
        cyc(0, 0, 0, 0, "idle");

        // One-shot term=3 div=0.
        s_term = 4'd3; s_div = 8'd0; s_auto = 1'b0; s_start = 1'b1;
        cyc(0, 1, 0, 0, "os_start");
        s_start = 1'b0;
        cyc(1, 1, 0, 0, "os_c1");
        cyc(2, 1, 0, 0, "os_c2");
        cyc(3, 0, 1, 0, "os_done");
        cyc(3, 0, 0, 0, "os_hold");

        // Prescaled one-shot term=2 div=3: increments every 4 cycles.
        s_term = 4'd2; s_div = 8'd3; s_start = 1'b1;
        cyc(0, 1, 0, 0, "ps_start");
        s_start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 8)      cyc(2, 0, 1, 0, "ps_done");
            else if (k >= 4) cyc(1, 1, 0, 0, "ps_c1");
            else             cyc(0, 1, 0, 0, "ps_c0");
        end
        cyc(2, 0, 0, 0, "ps_hold");

        // Auto-reload term=2 div=0, with a start attempt while busy.
        s_term = 4'd2; s_div = 8'd0; s_auto = 1'b1; s_start = 1'b1;
        cyc(0, 1, 0, 0, "ar_start");
        s_start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            int w;
            if (k == 10) begin
                s_start = 1'b1; s_term = 4'd9; s_auto = 1'b0; s_div = 8'd5;
            end else begin
                s_start = 1'b0;
            end
            w = (k / 2 > 15) ? 15 : k / 2;
            if (k % 2 == 1) cyc(1, 1, 0, 4'(w), (k == 10) ? "ar_busy_start" : "ar_odd");
            else            cyc(0, 1, 1, 4'(w), (k == 10) ? "ar_busy_start" : "ar_even");
        end
        s_start = 1'b0;
        s_stop = 1'b1;
        cyc(0, 0, 0, 15, "ar_stop");
        s_stop = 1'b0;
        cyc(0, 0, 0, 15, "ar_idle");

        // Pause mid-count at cnt=2, term=5.
        s_term = 4'd5; s_div = 8'd0; s_auto = 1'b0; s_start = 1'b1;
        cyc(0, 1, 0, 0, "pz_start");
        s_start = 1'b0;
        cyc(1, 1, 0, 0, "pz_c1");
        cyc(2, 1, 0, 0, "pz_c2");
        s_pause = 1'b1;
        for (int k = 0; k < 5; k++) cyc(2, 1, 0, 0, "pz_hold");
        s_pause = 1'b0;
        cyc(2, 1, 0, 0, "pz_resume");
        cyc(3, 1, 0, 0, "pz_c3");
        cyc(4, 1, 0, 0, "pz_c4");
        cyc(5, 0, 1, 0, "pz_done");

        // Stop while in HOLD.
        s_start = 1'b1;
        cyc(0, 1, 0, 0, "sh_start");
        s_start = 1'b0;
        cyc(1, 1, 0, 0, "sh_c1");
        cyc(2, 1, 0, 0, "sh_c2");
        s_pause = 1'b1;
        cyc(2, 1, 0, 0, "sh_hold");
        s_stop = 1'b1;
        cyc(2, 0, 0, 0, "sh_stop");
        s_stop = 1'b0; s_pause = 1'b0;
        cyc(2, 0, 0, 0, "sh_idle");

        // Start with term=0: immediate done, never busy.
        s_term = 4'd0; s_start = 1'b1;
        cyc(0, 0, 1, 0, "t0_done");
        s_start = 1'b0;
        cyc(0, 0, 0, 0, "t0_after");

        // Stop coinciding with terminal tick.
        s_term = 4'd2; s_start = 1'b1;
        cyc(0, 1, 0, 0, "st_start");
        s_start = 1'b0;
        cyc(1, 1, 0, 0, "st_c1");
        s_stop = 1'b1;
        cyc(1, 0, 0, 0, "st_stop_tick");
        s_stop = 1'b0;
        cyc(1, 0, 0, 0, "st_idle");

        // Reset mid-run at cnt=5 after one reload, then a fresh one-shot.
        s_term = 4'd7; s_auto = 1'b1; s_start = 1'b1;
        cyc(0, 1, 0, 0, "rm_start");
        s_start = 1'b0;
        for (int k = 1; k <= 6; k++) cyc(4'(k), 1, 0, 0, "rm_up");
        cyc(0, 1, 1, 1, "rm_wrap");
        for (int k = 1; k <= 5; k++) cyc(4'(k), 1, 0, 1, "rm_up2");
        s_reset = 1'b0;
        cyc(0, 0, 0, 0, "rm_reset");
        s_reset = 1'b1;
        cyc(0, 0, 0, 0, "rm_idle");
        s_term = 4'd3; s_auto = 1'b0; s_start = 1'b1;
        cyc(0, 1, 0, 0, "fr_start");
        s_start = 1'b0;
        cyc(1, 1, 0, 0, "fr_c1");
        cyc(2, 1, 0, 0, "fr_c2");
        cyc(3, 0, 1, 0, "fr_done");
        cyc(3, 0, 0, 0, "fr_hold");

        stim_done = 1'b1;
    end

    // Drain the scoreboard within a bounded number of cycles, then report.
    initial begin
        int guard;
        wait (stim_done);
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
